posit_fma_sched: RTL and testbench
==================================

Name: posit_fma_sched

Overview:
- Round-robin issue scheduler that shares one posit FMA datapath (A*B+C*D, 4-operand, in_pre/out_pre precision modes) among NUM_REQ requesters.
- Accepts one operation per cycle, drives the datapath operand/mode inputs and start strobe, and tracks in-flight operations with a tag pipeline matched to the datapath latency.
- Returns each result tagged with the originating requester.
- Enforces a drain-before-mode-change rule so precision reconfiguration never overlaps in-flight work.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width, = clog2(NUM_REQ).
- FMA_LAT, 6, cycles from datapath input capture to fma_result valid.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a, req_b, req_c, req_d  in  NUM_REQ*32 each  packed operands, requester i at [32i+31:32i].
- req_in_pre  in  NUM_REQ*2  input precision mode per requester.
- req_out_pre  in  NUM_REQ*2  output precision mode per requester.
- fma_start  out  1  issue strobe to datapath.
- fma_a, fma_b, fma_c, fma_d  out  32 each  operands to datapath.
- fma_in_pre, fma_out_pre  out  2 each  modes to datapath.
- fma_result  in  32  datapath result.
- rsp_valid  out  1  result valid.
- rsp_id  out  ID_W  requester owning rsp_data.
- rsp_data  out  32  result, = fma_result.
- inflight  out  clog2(FMA_LAT+1)+1  operations issued but not yet returned.
- busy  out  1  inflight != 0 or state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - req_ready=0, fma_start=0, fma_a..d=0, fma_in_pre=fma_out_pre=0, rsp_valid=0, rsp_id=0, inflight=0.
  - rr_ptr=0, cur_mode=0, tag pipeline cleared, state=IDLE.
- Handshake: transfer when req_valid[i] & req_ready[i] at a clock edge.
  - req_ready is combinational from req_valid, state and rr_ptr.
  - At most one bit set per cycle.
  - Requester holds valid/operands/mode stable until accepted.
- Arbitration: candidate = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. On each accept, rr_ptr <= winner+1 mod NUM_REQ.
- Mode = {in_pre, out_pre}, 4 bits.
- FSM:
  - IDLE/RUN (single state RUN after reset; IDLE equals RUN with inflight=0):
    - If the candidate's mode == cur_mode, or inflight==0 (counting a return in this cycle), accept it.
    - Otherwise latch lock_id=candidate and go to DRAIN; no accept this cycle.
  - DRAIN:
    - req_ready=0 for all requesters.
    - When inflight==0, accept lock_id if still valid and return to RUN.
    - If lock_id has dropped valid, return to RUN without issue.
  - Requesters that match cur_mode do not bypass a DRAIN; this prevents starvation of mode changers.
- Issue (accept at edge t):
  - fma_start=1 and fma_* = winner's operands/mode during cycle t+1 (registered outputs). fma_start=0 otherwise; fma_* hold last values.
  - cur_mode <= winner mode.
- Tag pipeline:
  - FMA_LAT-deep shift of {valid, id}; stage 0 loaded with {fma_start, issued id} each cycle.
  - rsp_valid/rsp_id = final stage, so rsp_valid is high during cycle t+1+FMA_LAT.
- Throughput: back-to-back accepts allowed every cycle in the same mode; results return in issue order, one per cycle.
- inflight: +1 on accept, -1 when rsp_valid; both in the same cycle leaves it unchanged. Never exceeds FMA_LAT+1.
- No result backpressure: requesters must sink rsp on the rsp_valid cycle.
- Reset mid-operation: all tags dropped, so results from pre-reset issues never assert rsp_valid; DRAIN is abandoned.

Decomposition:
- Shared package (posit_fma_pkg): mode typedef {in_pre, out_pre}, precision encodings, FMA_LAT_DEFAULT=6, operand width 32.
- One sub-module, rr_arbiter: NUM_REQ request vector + pointer -> one-hot grant + index. Parameterised, combinational, reused elsewhere.
- Tag pipeline and FSM stay in posit_fma_sched.

Test Plan:
- Single op, requester 2, mode 0, accept at edge t -> fma_start=1 in cycle t+1 with matching operands; rsp_valid=1, rsp_id=2 in cycle t+7; inflight 1 then 0.
- All 4 requesters valid continuously, same mode -> grants in order 0,1,2,3,0; fma_start=1 every cycle; 4 consecutive responses with ids 0,1,2,3; inflight saturates at 7 and never exceeds it.
- rr_ptr=1, requesters 0 and 3 valid -> grant 3 first, then 0.
- Requester 0 issues in mode 0, then requester 1 requests mode 5 -> DRAIN entered, req_ready=0 for 6 cycles. Requester 1 is accepted the cycle inflight reaches 0; fma_in_pre/out_pre = 01/01 on the following cycle.
- rst asserted 3 cycles after issuing 2 ops -> all outputs at reset values next cycle; no rsp_valid for the following 10 cycles.
- Requester locked in DRAIN drops valid -> returns to RUN with no issue; next valid requester is served normally.

Source files
------------

// File: rtl/posit_fma_pkg.sv
// Shared definitions for the posit FMA datapath and its issue scheduler.
package posit_fma_pkg;

    localparam int OPND_W          = 32;
    localparam int FMA_LAT_DEFAULT = 6;

    // Precision encodings carried on in_pre / out_pre.
    typedef enum logic [1:0] {
        PREC_P8   = 2'd0,
        PREC_P16  = 2'd1,
        PREC_P32  = 2'd2,
        PREC_RSVD = 2'd3
    } prec_e;

    // Datapath configuration; the 4-bit value {in_pre, out_pre} is the mode.
    typedef struct packed {
        logic [1:0] in_pre;
        logic [1:0] out_pre;
    } mode_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after
// ptr (wrapping) wins; grant is one-hot, or zero when nothing requests.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int best_d;

    // Pick the active request with the smallest wrapped distance from ptr.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        best_d = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (((i - int'(ptr) + NUM_REQ) % NUM_REQ) < best_d)) begin
                best_d = (i - int'(ptr) + NUM_REQ) % NUM_REQ;
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = ID_W'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/posit_fma_sched.sv
// Round-robin issue scheduler sharing one posit FMA datapath among several
// requesters. Tracks in-flight work with a tag pipeline matched to the
// datapath latency and drains the pipe before any precision-mode change.
module posit_fma_sched
    import posit_fma_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int FMA_LAT = FMA_LAT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*32-1:0]     req_a,
    input  logic [NUM_REQ*32-1:0]     req_b,
    input  logic [NUM_REQ*32-1:0]     req_c,
    input  logic [NUM_REQ*32-1:0]     req_d,
    input  logic [NUM_REQ*2-1:0]      req_in_pre,
    input  logic [NUM_REQ*2-1:0]      req_out_pre,
    output logic                      fma_start,
    output logic [31:0]               fma_a,
    output logic [31:0]               fma_b,
    output logic [31:0]               fma_c,
    output logic [31:0]               fma_d,
    output logic [1:0]                fma_in_pre,
    output logic [1:0]                fma_out_pre,
    input  logic [31:0]               fma_result,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [31:0]               rsp_data,
    output logic [$clog2(FMA_LAT+1):0] inflight,
    output logic                      busy
);

    localparam int CNT_W = $clog2(FMA_LAT+1) + 1;

    typedef enum logic {ST_RUN, ST_DRAIN} state_e;

    state_e            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   lock_id;
    logic [ID_W-1:0]   iss_id;
    mode_t             cur_mode;

    logic [OPND_W-1:0] a_arr [NUM_REQ];
    logic [OPND_W-1:0] b_arr [NUM_REQ];
    logic [OPND_W-1:0] c_arr [NUM_REQ];
    logic [OPND_W-1:0] d_arr [NUM_REQ];
    mode_t             mode_arr [NUM_REQ];

    logic [NUM_REQ-1:0] cand_gnt;
    logic [ID_W-1:0]    cand_idx;
    logic               cand_any;

    logic               acc;
    logic               go_drain;
    logic [ID_W-1:0]    win_idx;
    logic               drained_now;

    logic               tag_vld_p [FMA_LAT];
    logic [ID_W-1:0]    tag_id_p  [FMA_LAT];

    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) return '0;
        return idx + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g]    = req_a[OPND_W*g +: OPND_W];
        assign b_arr[g]    = req_b[OPND_W*g +: OPND_W];
        assign c_arr[g]    = req_c[OPND_W*g +: OPND_W];
        assign d_arr[g]    = req_d[OPND_W*g +: OPND_W];
        assign mode_arr[g] = {req_in_pre[2*g +: 2], req_out_pre[2*g +: 2]};
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (cand_gnt),
        .idx (cand_idx),
        .any (cand_any)
    );

    // The datapath currently holds the last issued mode.
    assign cur_mode    = {fma_in_pre, fma_out_pre};
    // Pipe is empty once any result returning this cycle is discounted.
    assign drained_now = (inflight == CNT_W'(rsp_valid));
    assign rsp_valid   = tag_vld_p[FMA_LAT-1];
    assign rsp_id      = tag_id_p[FMA_LAT-1];
    assign rsp_data    = fma_result;
    assign busy        = (inflight != '0) || (state == ST_DRAIN);

    // Accept decision: same-mode or empty pipe issues now; a mode change
    // locks the candidate and waits in DRAIN, blocking everyone else.
    always_comb begin
        req_ready = '0;
        acc       = 1'b0;
        go_drain  = 1'b0;
        win_idx   = cand_idx;
        if (state == ST_RUN) begin
            if (cand_any) begin
                if ((mode_arr[cand_idx] == cur_mode) || drained_now) begin
                    req_ready = cand_gnt;
                    acc       = 1'b1;
                end else begin
                    go_drain = 1'b1;
                end
            end
        end else begin
            win_idx = lock_id;
            if ((inflight == '0) && req_valid[lock_id]) begin
                req_ready[lock_id] = 1'b1;
                acc                = 1'b1;
            end
        end
    end

    // Issue registers, FSM, round-robin pointer and in-flight counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            rr_ptr      <= '0;
            lock_id     <= '0;
            iss_id      <= '0;
            fma_start   <= 1'b0;
            fma_a       <= '0;
            fma_b       <= '0;
            fma_c       <= '0;
            fma_d       <= '0;
            fma_in_pre  <= '0;
            fma_out_pre <= '0;
            inflight    <= '0;
        end else begin
            fma_start <= acc;
            if (acc) begin
                fma_a       <= a_arr[win_idx];
                fma_b       <= b_arr[win_idx];
                fma_c       <= c_arr[win_idx];
                fma_d       <= d_arr[win_idx];
                fma_in_pre  <= mode_arr[win_idx].in_pre;
                fma_out_pre <= mode_arr[win_idx].out_pre;
                iss_id      <= win_idx;
                rr_ptr      <= ptr_after(win_idx);
            end
            case (state)
                ST_RUN: begin
                    if (go_drain) begin
                        lock_id <= cand_idx;
                        state   <= ST_DRAIN;
                    end
                end
                default: begin
                    if (acc || !req_valid[lock_id]) state <= ST_RUN;
                end
            endcase
            inflight <= inflight + CNT_W'(acc) - CNT_W'(rsp_valid);
        end
    end

    // Tag pipeline: stage 0 captures the issue strobe, last stage is the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FMA_LAT; k++) begin
                tag_vld_p[k] <= 1'b0;
                tag_id_p[k]  <= '0;
            end
        end else begin
            tag_vld_p[0] <= fma_start;
            tag_id_p[0]  <= iss_id;
            for (int k = 1; k < FMA_LAT; k++) begin
                tag_vld_p[k] <= tag_vld_p[k-1];
                tag_id_p[k]  <= tag_id_p[k-1];
            end
        end
    end

endmodule

// File: tb/tb_posit_fma_sched.sv
// Directed bench for posit_fma_sched: vector table of single issues plus
// hand-written sequences for round-robin, drain, reset and lock-drop cases.
module tb_posit_fma_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int FMA_LAT = 6;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*32-1:0]  req_a, req_b, req_c, req_d;
    logic [NUM_REQ*2-1:0]   req_in_pre, req_out_pre;
    logic                   fma_start;
    logic [31:0]            fma_a, fma_b, fma_c, fma_d;
    logic [1:0]             fma_in_pre, fma_out_pre;
    logic [31:0]            fma_result;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [31:0]            rsp_data;
    logic [3:0]             inflight;
    logic                   busy;

    logic [31:0] cyc = 32'd0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         id;
        logic [31:0] a, b, c, d;
        logic [1:0]  ip, op;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;
    assign fma_result = 32'hA500_0000 ^ cyc;

    posit_fma_sched #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .FMA_LAT (FMA_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_c       (req_c),
        .req_d       (req_d),
        .req_in_pre  (req_in_pre),
        .req_out_pre (req_out_pre),
        .fma_start   (fma_start),
        .fma_a       (fma_a),
        .fma_b       (fma_b),
        .fma_c       (fma_c),
        .fma_d       (fma_d),
        .fma_in_pre  (fma_in_pre),
        .fma_out_pre (fma_out_pre),
        .fma_result  (fma_result),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .inflight    (inflight),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d,
                           input logic [1:0] ip, input logic [1:0] op);
        req_a[32*i +: 32]      = a;
        req_b[32*i +: 32]      = b;
        req_c[32*i +: 32]      = c;
        req_d[32*i +: 32]      = d;
        req_in_pre[2*i +: 2]   = ip;
        req_out_pre[2*i +: 2]  = op;
        req_valid[i]           = 1'b1;
    endtask

    task automatic drop(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (inflight != 4'd0 && n < 30) begin
            step();
            n++;
        end
        chk("wait_idle_inflight", 32'(inflight), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        vecs[0] = '{id: 2, a: 32'h0000_1111, b: 32'h0000_2222, c: 32'h0000_3333, d: 32'h0000_4444, ip: 2'd0, op: 2'd0};
        vecs[1] = '{id: 0, a: 32'hDEAD_BEEF, b: 32'h1234_5678, c: 32'h8000_0001, d: 32'h7FFF_FFFF, ip: 2'd1, op: 2'd2};
        vecs[2] = '{id: 1, a: 32'hFFFF_FFFF, b: 32'h0000_0000, c: 32'hCAFE_F00D, d: 32'h0BAD_C0DE, ip: 2'd2, op: 2'd3};
        vecs[3] = '{id: 3, a: 32'h4000_0000, b: 32'hC000_0000, c: 32'h0000_0001, d: 32'hA5A5_5A5A, ip: 2'd0, op: 2'd0};

        rst         = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        req_c       = '0;
        req_d       = '0;
        req_in_pre  = '0;
        req_out_pre = '0;
        step();
        step();
        chk("rst_ready",     32'(req_ready),  32'd0);
        chk("rst_fma_start", 32'(fma_start),  32'd0);
        chk("rst_fma_a",     fma_a,           32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("rst_inflight",  32'(inflight),   32'd0);
        chk("rst_busy",      32'(busy),       32'd0);
        rst = 1'b0;
        step();

        // Table-driven single issues, each with full latency tracking.
        for (int v = 0; v < 4; v++) begin
            set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d, vecs[v].ip, vecs[v].op);
            #1;
            chk("vec_ready", 32'(req_ready), 32'(1) << vecs[v].id);
            step();
            drop(vecs[v].id);
            chk("vec_start",   32'(fma_start),   32'd1);
            chk("vec_a",       fma_a,            vecs[v].a);
            chk("vec_b",       fma_b,            vecs[v].b);
            chk("vec_c",       fma_c,            vecs[v].c);
            chk("vec_d",       fma_d,            vecs[v].d);
            chk("vec_in_pre",  32'(fma_in_pre),  32'(vecs[v].ip));
            chk("vec_out_pre", 32'(fma_out_pre), 32'(vecs[v].op));
            chk("vec_infl1",   32'(inflight),    32'd1);
            repeat (5) step();
            chk("vec_rsp_early", 32'(rsp_valid), 32'd0);
            step();
            chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("vec_rsp_id",    32'(rsp_id),    32'(vecs[v].id));
            chk("vec_rsp_data",  rsp_data,       32'hA500_0000 ^ cyc);
            chk("vec_infl_rsp",  32'(inflight),  32'd1);
            step();
            chk("vec_rsp_done",  32'(rsp_valid), 32'd0);
            chk("vec_infl0",     32'(inflight),  32'd0);
            chk("vec_idle",      32'(busy),      32'd0);
        end

        // All four requesters continuously valid in the same mode.
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 32'h3000_0000, 32'h4000_0000, 2'd0, 2'd0);
        #1;
        for (int k = 0; k < 12; k++) begin
            chk("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
            if (k >= 1) begin
                chk("rr_start", 32'(fma_start), 32'd1);
                chk("rr_fma_a", fma_a, 32'h1000_0000 + 32'((k - 1) % 4));
            end
            chk("rr_inflight", 32'(inflight), (k < 7) ? 32'(k) : 32'd7);
            if (k >= 7) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rr_rsp_id",    32'(rsp_id),    32'((k - 7) % 4));
            end else begin
                chk("rr_rsp_quiet", 32'(rsp_valid), 32'd0);
            end
            step();
        end
        req_valid = '0;
        wait_idle();

        // Pointer at 1 with requesters 0 and 3 valid: 3 wins, then 0.
        set_req(0, 32'h0000_00AA, 32'd1, 32'd2, 32'd3, 2'd0, 2'd0);
        #1;
        step();
        drop(0);
        wait_idle();
        set_req(0, 32'h0000_0A00, 32'd1, 32'd2, 32'd3, 2'd0, 2'd0);
        set_req(3, 32'h0000_0A03, 32'd1, 32'd2, 32'd3, 2'd0, 2'd0);
        #1;
        chk("ptr_first_3", 32'(req_ready), 32'h8);
        step();
        drop(3);
        #1;
        chk("ptr_then_0", 32'(req_ready), 32'h1);
        step();
        drop(0);
        wait_idle();

        // Mode change forces a drain before requester 1 issues in mode 5.
        set_req(0, 32'h0000_0D00, 32'd1, 32'd2, 32'd3, 2'd0, 2'd0);
        #1;
        chk("drain_acc0", 32'(req_ready), 32'h1);
        step();
        drop(0);
        set_req(1, 32'h0000_0D01, 32'd5, 32'd6, 32'd7, 2'd1, 2'd1);
        #1;
        chk("drain_block_run", 32'(req_ready), 32'h0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("drain_block", 32'(req_ready), 32'h0);
            chk("drain_busy",  32'(busy),      32'd1);
        end
        step();
        chk("drain_infl0",  32'(inflight),  32'd0);
        chk("drain_accept", 32'(req_ready), 32'h2);
        step();
        drop(1);
        chk("drain_start",   32'(fma_start),   32'd1);
        chk("drain_a",       fma_a,            32'h0000_0D01);
        chk("drain_in_pre",  32'(fma_in_pre),  32'd1);
        chk("drain_out_pre", 32'(fma_out_pre), 32'd1);
        wait_idle();

        // Reset in the middle of two outstanding operations.
        set_req(0, 32'h0000_0E00, 32'd1, 32'd2, 32'd3, 2'd0, 2'd0);
        set_req(1, 32'h0000_0E01, 32'd1, 32'd2, 32'd3, 2'd0, 2'd0);
        #1;
        chk("rst_mid_acc0", 32'(req_ready), 32'h1);
        step();
        drop(0);
        #1;
        chk("rst_mid_acc1", 32'(req_ready), 32'h2);
        step();
        drop(1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_start",  32'(fma_start),  32'd0);
        chk("rst_mid_a",      fma_a,           32'd0);
        chk("rst_mid_in_pre", 32'(fma_in_pre), 32'd0);
        chk("rst_mid_rsp",    32'(rsp_valid),  32'd0);
        chk("rst_mid_rsp_id", 32'(rsp_id),     32'd0);
        chk("rst_mid_infl",   32'(inflight),   32'd0);
        chk("rst_mid_busy",   32'(busy),       32'd0);
        chk("rst_mid_ready",  32'(req_ready),  32'd0);
        seen = 1'b0;
        repeat (10) begin
            step();
            if (rsp_valid) seen = 1'b1;
        end
        chk("rst_mid_no_rsp", 32'(seen), 32'd0);

        // Locked requester withdraws during DRAIN; the next one is served.
        set_req(0, 32'h0000_0F00, 32'd1, 32'd2, 32'd3, 2'd0, 2'd0);
        #1;
        step();
        drop(0);
        set_req(1, 32'h0000_0F01, 32'd1, 32'd2, 32'd3, 2'd1, 2'd1);
        #1;
        chk("lock_block", 32'(req_ready), 32'h0);
        step();
        drop(1);
        set_req(2, 32'h0000_0F02, 32'd1, 32'd2, 32'd3, 2'd0, 2'd0);
        #1;
        chk("lock_drain_ready", 32'(req_ready), 32'h0);
        chk("lock_drain_busy",  32'(busy),      32'd1);
        step();
        chk("lock_no_issue", 32'(fma_start), 32'd0);
        chk("lock_serve2",   32'(req_ready), 32'h4);
        step();
        drop(2);
        chk("lock_start2",  32'(fma_start),  32'd1);
        chk("lock_a2",      fma_a,           32'h0000_0F02);
        chk("lock_in_pre2", 32'(fma_in_pre), 32'd0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
